mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates the single-ported unified instruction/data memory between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Sequences each access over a request/ack memory handshake, with a range check and a timeout.
- Drives wait flags into the pipeline hazard control, which converts them into F/D/E/M stalls and bubbles.
- Memory-stage accesses have fixed priority over fetch, because the memory stage holds the older instruction.

Parameters:
- MEM_SIZE, 4096: byte size of memory. Any access with addr > MEM_SIZE-10 (fetch) or addr > MEM_SIZE-8 (data) is out of range.
- TIMEOUT, 16: maximum number of cycles in an ISSUE state without mem_ack before the access is aborted with an error.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- f_req  in  1  fetch read request; level signal, held until f_done
- f_addr  in  64  fetch byte address (PC)
- f_done  out  1  one-cycle pulse; fetch access complete
- f_rdata  out  80  10 instruction bytes; valid while f_done=1
- f_err  out  1  with f_done; address error (stat ADR)
- m_req  in  1  data request; level signal, held until m_done
- m_we  in  1  1 = write, 0 = read
- m_addr  in  64  data byte address
- m_wdata  in  64  write data
- m_done  out  1  one-cycle pulse; data access complete
- m_rdata  out  64  read data; valid while m_done=1
- m_err  out  1  with m_done; address error
- mem_req  out  1  memory request; held high until mem_ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  80  memory read data; valid with mem_ack
- mem_err  in  1  memory error; valid with mem_ack
- fetch_wait  out  1  to hazard control: f_req & ~f_done
- mem_wait  out  1  to hazard control: m_req & ~m_done

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, f_done, m_done, f_err, m_err = 0.
  - mem_addr, mem_wdata, f_rdata, m_rdata, timeout counter = 0.
- A reset in any state abandons the transaction in flight: mem_req drops the next cycle and no done pulse is produced.
- All outputs are registered except fetch_wait and mem_wait, which are combinational from the inputs and the registered done pulses.

State machine: IDLE, ISSUE_M, ISSUE_F, RESP.
- IDLE:
  - If m_req=1: latch m_addr/m_we/m_wdata. If in range, go to ISSUE_M with mem_req=1 the next cycle; otherwise go to RESP with m_err=1 and issue no memory request.
  - Else if f_req=1: same handling with f_addr and mem_we=0; go to ISSUE_F or to RESP with f_err=1.
  - If both requests are high, m wins. The fetch request stays pending, fetch_wait stays high, and fetch is granted on a later IDLE cycle in which m_req=0.
- ISSUE_x:
  - mem_req=1 and the address/data outputs stay stable. The counter clears on entry and increments each cycle without mem_ack.
  - On mem_ack=1: go to RESP and capture mem_rdata and mem_err. m_rdata takes mem_rdata[63:0]; f_rdata takes all 80 bits. Writes return m_rdata=0.
  - If the counter reaches TIMEOUT-1 with no ack: go to RESP with x_err=1 and drop mem_req.
  - mem_ack in the same cycle as the timeout: the ack wins.
  - If the requester drops its req mid-access, the access still completes and done still pulses; the requester ignores it.
- RESP:
  - Exactly one cycle. x_done=1 for the owning port only; the other done stays 0. mem_req=0.
  - No new grant is made in this cycle, even if requests are high. Go to IDLE.
  - done and err clear the next cycle; rdata holds its value until the next RESP.
- Minimum latency:
  - In-range access: request sampled in IDLE at cycle 0 → mem_req high in cycle 1 → ack in cycle 1 → done in cycle 2 → IDLE in cycle 3. A requester that keeps req high is granted again in cycle 3.
  - Out-of-range access: done with err in cycle 1.
- Range-check arithmetic is unsigned 64-bit. Addresses near 2^64 must not wrap into range: compare addr against MEM_SIZE-10 (or MEM_SIZE-8), never addr+10 against MEM_SIZE.

Test Plan:
- Fetch read, f_addr=0x40, memory acks 2 cycles after mem_req → mem_addr=0x40, mem_we=0; f_done pulses 1 cycle after the ack with f_rdata = mem_rdata and f_err=0; fetch_wait is high from the request until f_done.
- f_req and m_req rise in the same cycle (m_we=1, m_addr=0x100, m_wdata=0x1122334455667788), ack in 1 cycle → write issued first with mem_wdata = that value; m_done, then one RESP cycle, then fetch is issued; no other m_done/f_done pulses.
- Data read at m_addr=MEM_SIZE-7 = 0xFF9, and a separate fetch at f_addr=0xFFFFFFFFFFFFFFF8 → mem_req never rises; done with err=1 in cycle 1.
- No mem_ack with TIMEOUT=16 → mem_req high for exactly 16 cycles, then done with err=1 and mem_req=0. A repeat run with the ack arriving on cycle 16 → err=0.
- Ack with mem_err=1 → m_err=1 with m_done; m_req held high afterwards → re-granted after the RESP/IDLE cycle.
- rst asserted during ISSUE_F → next cycle IDLE, mem_req=0, no f_done pulse; a new request is serviced normally afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified single-ported memory: the memory stage has priority over fetch, and each
// access is range-checked, issued over a req/ack handshake with a timeout, and answered by a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int MEM_SIZE = 4096,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_done,
  output logic [79:0] f_rdata,
  output logic        f_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        m_done,
  output logic [63:0] m_rdata,
  output logic        m_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [79:0] mem_rdata,
  input  logic        mem_err,
  output logic        fetch_wait,
  output logic        mem_wait,
  output logic [1:0]  dbg_state
);
  // Handshake: a requester holds x_req high until it sees x_done for one cycle; the memory side
  // sees mem_req held with stable mem_addr/mem_we/mem_wdata until the cycle in which mem_ack is high.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE_M = 2'd1, ISSUE_F = 2'd2, RESP = 2'd3} state_t;

  // Limits are compared against the raw address so addresses near 2^64 cannot wrap into range.
  localparam logic [63:0]      F_LIMIT  = 64'(MEM_SIZE - 10);
  localparam logic [63:0]      M_LIMIT  = 64'(MEM_SIZE - 8);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mem_req_n, mem_we_n, f_done_n, m_done_n, f_err_n, m_err_n;
  logic [63:0]      mem_addr_n, mem_wdata_n, m_rdata_n;
  logic [79:0]      f_rdata_n;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    f_done_n    = 1'b0;
    m_done_n    = 1'b0;
    f_err_n     = 1'b0;
    m_err_n     = 1'b0;
    f_rdata_n   = f_rdata;
    m_rdata_n   = m_rdata;
    case (state)
      IDLE: begin
        if (m_req) begin
          mem_addr_n  = m_addr;
          mem_wdata_n = m_wdata;
          if (m_addr > M_LIMIT) begin
            state_n  = RESP;
            m_done_n = 1'b1;
            m_err_n  = 1'b1;
            mem_we_n = 1'b0;
          end else begin
            state_n   = ISSUE_M;
            mem_req_n = 1'b1;
            mem_we_n  = m_we;
            cnt_n     = '0;
          end
        end else if (f_req) begin
          mem_addr_n = f_addr;
          mem_we_n   = 1'b0;
          if (f_addr > F_LIMIT) begin
            state_n  = RESP;
            f_done_n = 1'b1;
            f_err_n  = 1'b1;
          end else begin
            state_n   = ISSUE_F;
            mem_req_n = 1'b1;
            cnt_n     = '0;
          end
        end
      end
      ISSUE_M, ISSUE_F: begin
        if (mem_ack) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          if (state == ISSUE_M) begin
            m_done_n  = 1'b1;
            m_err_n   = mem_err;
            m_rdata_n = mem_we ? 64'd0 : mem_rdata[63:0];
          end else begin
            f_done_n  = 1'b1;
            f_err_n   = mem_err;
            f_rdata_n = mem_rdata;
          end
        end else if (cnt == CNT_LAST) begin
          // Ack never came: abort and report an address error to the owner.
          state_n   = RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          if (state == ISSUE_M) begin
            m_done_n = 1'b1;
            m_err_n  = 1'b1;
          end else begin
            f_done_n = 1'b1;
            f_err_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_done    <= 1'b0;
      m_done    <= 1'b0;
      f_err     <= 1'b0;
      m_err     <= 1'b0;
      f_rdata   <= '0;
      m_rdata   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      f_done    <= f_done_n;
      m_done    <= m_done_n;
      f_err     <= f_err_n;
      m_err     <= m_err_n;
      f_rdata   <= f_rdata_n;
      m_rdata   <= m_rdata_n;
    end
  end

  assign fetch_wait = f_req & ~f_done;
  assign mem_wait   = m_req & ~m_done;
  assign dbg_state  = state;
endmodule
